// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default address width and Gray/binary helpers.
// Helpers work on zero-extended values of any width up to GRAY_MAXW bits.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int GRAY_MAXW     = 16;

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] gray);
    logic [GRAY_MAXW-1:0] bin;
    bin[GRAY_MAXW-1] = gray[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      bin[i] = gray[i] ^ bin[i+1];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer of parameterized width, reset to zero.
// Shared by the write-side and read-side pointer blocks.
module fifo_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full, fill-count, almost-full and sticky overflow for the async FIFO.
// Define FIFO_WPTR_RPTR_SYNC_EN to synchronize i_rq2_rptr internally (two extra flops).
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = 12
) (
  input  logic                i_wr_clk,
  input  logic                i_wr_rst_n,
  input  logic                i_wr_en,
  input  logic [ADDRSIZE:0]   i_rq2_rptr,
  input  logic                i_ovf_clr,
  output logic [ADDRSIZE-1:0] o_wr_addr,
  output logic [ADDRSIZE:0]   o_wr_ptr,
  output logic                o_full,
  output logic                o_almost_full,
  output logic [ADDRSIZE:0]   o_wr_count,
  output logic                o_overflow
);

  localparam int PTRW = ADDRSIZE + 1;
  localparam logic [PTRW-1:0] THRESH_W = PTRW'(AFULL_THRESH);

  logic [PTRW-1:0]     rptrSync;
  logic [PTRW-1:0]     rptrBin;
  logic [PTRW-1:0]     fullCmp;
  logic                wrInc;

  logic [PTRW-1:0]     wbin_q, wbin_d;
  logic [PTRW-1:0]     wgray_q, wgray_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [PTRW-1:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                almostFull_q, almostFull_d;
  logic                overflow_q, overflow_d;

`ifdef FIFO_WPTR_RPTR_SYNC_EN
  fifo_sync_2ff #(
    .WIDTH (PTRW)
  ) u_rptr_sync (
    .clk_i  (i_wr_clk),
    .rst_ni (i_wr_rst_n),
    .d_i    (i_rq2_rptr),
    .q_o    (rptrSync)
  );
`else
  assign rptrSync = i_rq2_rptr;
`endif

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted,
  // i.e. the binary pointers differ by exactly the depth.
  always_comb begin
    wrInc        = i_wr_en & ~full_q;
    wbin_d       = wbin_q + {{ADDRSIZE{1'b0}}, wrInc};
    wgray_d      = PTRW'(bin2gray(GRAY_MAXW'(wbin_d)));
    addr_d       = wbin_d[ADDRSIZE-1:0];
    rptrBin      = PTRW'(gray2bin(GRAY_MAXW'(rptrSync)));
    fullCmp      = {~rptrSync[ADDRSIZE:ADDRSIZE-1], rptrSync[ADDRSIZE-2:0]};
    full_d       = (wgray_d == fullCmp);
    count_d      = wbin_d - rptrBin;
    almostFull_d = (count_d >= THRESH_W);
    overflow_d   = (i_wr_en & full_q) | (overflow_q & ~i_ovf_clr);
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      almostFull_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_wr_addr     = addr_q;
  assign o_wr_ptr      = wgray_q;
  assign o_full        = full_q;
  assign o_almost_full = almostFull_q;
  assign o_wr_count    = count_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full against an occupancy-level reference model.
// Works with or without FIFO_WPTR_RPTR_SYNC_EN defined.
module tb_fifo_wptr_full;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 1 << ADDRSIZE;
  localparam int PTRSPAN  = 2 * DEPTH;
  localparam int THRESH   = 12;
`ifdef FIFO_WPTR_RPTR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                clk;
  logic                rstN;
  logic                wrEn;
  logic [ADDRSIZE:0]   rq2Rptr;
  logic                ovfClr;
  logic [ADDRSIZE-1:0] wrAddr;
  logic [ADDRSIZE:0]   wrPtr;
  logic                full;
  logic                almostFull;
  logic [ADDRSIZE:0]   wrCount;
  logic                overflow;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: accepted writes as a plain integer, read pointer seen after sync latency.
  int grayOf[PTRSPAN];
  int wrTotal;
  int rdPipe[2];
  int expAddr, expPtr, expCount;
  bit expFull, expAfull, expOvf;

  fifo_wptr_full #(
    .ADDRSIZE     (ADDRSIZE),
    .AFULL_THRESH (THRESH)
  ) dut (
    .i_wr_clk      (clk),
    .i_wr_rst_n    (rstN),
    .i_wr_en       (wrEn),
    .i_rq2_rptr    (rq2Rptr),
    .i_ovf_clr     (ovfClr),
    .o_wr_addr     (wrAddr),
    .o_wr_ptr      (wrPtr),
    .o_full        (full),
    .o_almost_full (almostFull),
    .o_wr_count    (wrCount),
    .o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int binOf(input int gray);
    for (int v = 0; v < PTRSPAN; v++) begin
      if (grayOf[v] == gray) return v;
    end
    return 0;
  endfunction

  task automatic modelReset();
    wrTotal   = 0;
    rdPipe[0] = 0;
    rdPipe[1] = 0;
    expAddr   = 0;
    expPtr    = 0;
    expCount  = 0;
    expFull   = 0;
    expAfull  = 0;
    expOvf    = 0;
  endtask

  task automatic modelStep(input bit we, input int rptrGray, input bit clr);
    int seenGray, fill;
    bit accepted;
    if (SYNC_LAT == 0) begin
      seenGray = rptrGray;
    end else begin
      seenGray  = rdPipe[1];
      rdPipe[1] = rdPipe[0];
      rdPipe[0] = rptrGray;
    end
    accepted = we && !expFull;
    wrTotal  = wrTotal + (accepted ? 1 : 0);
    fill     = (wrTotal - binOf(seenGray)) % PTRSPAN;
    if (fill < 0) fill = fill + PTRSPAN;
    expOvf   = (we && expFull) || (expOvf && !clr);
    expCount = fill;
    expFull  = (fill == DEPTH);
    expAfull = (fill >= THRESH);
    expAddr  = wrTotal % DEPTH;
    expPtr   = grayOf[wrTotal % PTRSPAN];
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ".addr"},  32'(wrAddr),     32'(expAddr));
    checkOutput({phase, ".ptr"},   32'(wrPtr),      32'(expPtr));
    checkOutput({phase, ".full"},  32'(full),       32'(expFull));
    checkOutput({phase, ".afull"}, 32'(almostFull), 32'(expAfull));
    checkOutput({phase, ".count"}, 32'(wrCount),    32'(expCount));
    checkOutput({phase, ".ovf"},   32'(overflow),   32'(expOvf));
  endtask

  task automatic applyStimulus(input string phase, input bit we, input int rptrGray, input bit clr);
    wrEn    = we;
    rq2Rptr = (ADDRSIZE+1)'(rptrGray);
    ovfClr  = clr;
    @(posedge clk);
    modelStep(we, rptrGray, clr);
    #1;
    checkAll(phase);
  endtask

  initial begin
    int rd, target;
    logic [ADDRSIZE:0] prevPtr;

    for (int v = 0; v < PTRSPAN; v++) grayOf[v] = v ^ (v >> 1);
    modelReset();
    rstN    = 1'b0;
    wrEn    = 1'b0;
    rq2Rptr = '0;
    ovfClr  = 1'b0;
    #1;
    checkAll("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;

    repeat (2) applyStimulus("idle", 1'b0, 0, 1'b0);

    $display("[TB] filling to full");
    for (int k = 1; k <= DEPTH; k++) applyStimulus("fill", 1'b1, 0, 1'b0);
    checkOutput("fillPtr", 32'(wrPtr), 32'h18);
    checkOutput("fillCount", 32'(wrCount), 32'(DEPTH));

    applyStimulus("ovfSet", 1'b1, 0, 1'b0);
    checkOutput("ovfSetFlag", 32'(overflow), 32'd1);
    applyStimulus("ovfClr", 1'b0, 0, 1'b1);
    checkOutput("ovfClrFlag", 32'(overflow), 32'd0);
    applyStimulus("ovfBoth", 1'b1, 0, 1'b1);
    checkOutput("ovfBothFlag", 32'(overflow), 32'd1);
    applyStimulus("ovfClr2", 1'b0, 0, 1'b1);

    $display("[TB] releasing from full");
    for (int k = 0; k <= SYNC_LAT; k++) applyStimulus("release", 1'b0, grayOf[4], 1'b0);
    checkOutput("releaseFull", 32'(full), 32'd0);
    checkOutput("releaseCount", 32'(wrCount), 32'd12);
    for (int k = 0; k < 4; k++) applyStimulus("refill", 1'b1, grayOf[4], 1'b0);
    checkOutput("refillFull", 32'(full), 32'd1);

    $display("[TB] wrap with tracking reader");
    rd = wrTotal - 2;
    for (int k = 0; k <= SYNC_LAT; k++) applyStimulus("drain", 1'b0, grayOf[rd % PTRSPAN], 1'b0);
    prevPtr = wrPtr;
    for (int k = 0; k < 40; k++) begin
      applyStimulus("wrap", 1'b1, grayOf[rd % PTRSPAN], 1'b0);
      checkOutput("wrapPtrStep", 32'($countones(prevPtr ^ wrPtr) <= 1), 32'd1);
      checkOutput("wrapNoFull", 32'(full), 32'd0);
      prevPtr = wrPtr;
      target = int'($urandom_range(1, 3));
      if (wrTotal - rd > target) rd = wrTotal - target;
    end

    $display("[TB] async reset mid-stream");
    @(negedge clk);
    rstN = 1'b0;
    #1;
    rstN = 1'b1;
    modelReset();
    for (int k = 0; k < 7; k++) applyStimulus("restart", 1'b1, 0, 1'b0);
    checkOutput("restartCount", 32'(wrCount), 32'd7);
    #3;
    rstN = 1'b0;
    modelReset();
    #1;
    checkAll("asyncRst");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus("postRst", 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-domain pointer and full-flag generator for the async FIFO.
- Sits directly upstream of the FIFO memory. Drives the memory's write address and full flag, and publishes a Gray-coded write pointer toward the read domain.
- Consumes the read pointer, Gray-coded, as synchronized into the write clock domain.
- Also derives a registered fill count, an almost-full flag and a sticky overflow error.

Parameters:
- ADDRSIZE, 4, number of memory address bits; FIFO depth = 2**ADDRSIZE.
- AFULL_THRESH, 12, fill count at or above which o_almost_full asserts; legal range 1..2**ADDRSIZE.

Ports:
- i_wr_clk  input  1  write-domain clock; the only clock.
- i_wr_rst_n  input  1  asynchronous, active-low reset for the write domain.
- i_wr_en  input  1  write request from the producer.
- i_rq2_rptr  input  ADDRSIZE+1  Gray read pointer already in the write domain (see optional feature).
- i_ovf_clr  input  1  clears the sticky overflow flag.
- o_wr_addr  output  ADDRSIZE  binary write address to the memory.
- o_wr_ptr  output  ADDRSIZE+1  Gray write pointer, registered, toward the read-domain synchronizer.
- o_full  output  1  FIFO full; drives the memory's full input.
- o_almost_full  output  1  registered fill count >= AFULL_THRESH.
- o_wr_count  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE.
- o_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Clock and reset:
  - Single clock domain: i_wr_clk.
  - Reset is asynchronous, active-low (i_wr_rst_n).
  - On reset all registers clear: wbin=0, o_wr_ptr=0, o_wr_addr=0, o_full=0, o_almost_full=0, o_wr_count=0, o_overflow=0.
- Write acceptance:
  - inc = i_wr_en & ~o_full.
  - The memory qualifies its own write with the same terms, so both agree on every accepted write.
- Pointer update:
  - wbin_next = wbin + inc, modulo 2**(ADDRSIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both register on posedge i_wr_clk.
  - o_wr_addr = wbin[ADDRSIZE-1:0], registered. The write at cycle N lands at the address shown during cycle N.
- Full detection:
  - o_full <= (wgray_next == {~i_rq2_rptr[ADDRSIZE:ADDRSIZE-1], i_rq2_rptr[ADDRSIZE-2:0]}).
  - Registered, so full asserts in the same edge that accepts the 2**ADDRSIZE-th outstanding write.
  - Full is pessimistic. It deasserts only after the read pointer change reaches i_rq2_rptr.
- Fill count:
  - rbin = Gray-to-binary(i_rq2_rptr).
  - o_wr_count <= wbin_next - rbin, in ADDRSIZE+1 bits.
  - o_almost_full <= ((wbin_next - rbin) >= AFULL_THRESH).
- Overflow:
  - i_wr_en & o_full sets o_overflow on the next edge.
  - i_ovf_clr clears it.
  - Simultaneous set and clear: set wins.
  - A rejected write never moves any pointer.
- Wrap-around: the extra MSB on wbin/gray distinguishes full from empty. A pointer wrap from 2**(ADDRSIZE+1)-1 to 0 changes exactly one Gray bit.
- Simultaneous write and read-pointer advance: the count uses both. Full does not assert if they net to below depth.
- Reset mid-operation: pointers return to 0 immediately, regardless of the clock. The read-domain block must be reset concurrently; that is the system-level rule.

Optional Feature:
- Macro: FIFO_WPTR_RPTR_SYNC_EN.
- Defined:
  - i_rq2_rptr is treated as the raw read-domain Gray pointer.
  - It passes through an internal 2-flop synchronizer on i_wr_clk, reset to 0, before any use.
  - This adds 2 cycles of full-deassert latency.
- Undefined: i_rq2_rptr is used directly and the external synchronizer is required.
- Port list is identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - the gray2bin and bin2gray functions, parameterized width;
  - the default ADDRSIZE constant, shared with the memory and read-side pointer block.
- One natural sub-module: fifo_sync_2ff, a parameterized width 2-flop synchronizer. It is instantiated only under FIFO_WPTR_RPTR_SYNC_EN and is reused by the read side.

Test Plan:
- Reset, then check idle outputs: hold i_rq2_rptr=0, no writes -> o_wr_addr=0, o_wr_ptr=0, o_full=0, o_wr_count=0, o_almost_full=0, o_overflow=0.
- Fill to full: 16 consecutive writes with i_rq2_rptr=0 -> o_wr_addr steps 0..15 and back to 0.
  - o_almost_full rises on the edge accepting the 12th write.
  - o_full=1 and o_wr_count=16 after the 16th; o_wr_ptr=5'b11000.
- Overflow and clear:
  - While full, pulse i_wr_en -> o_overflow=1 and pointer unchanged.
  - i_ovf_clr alone -> o_overflow=0.
  - i_ovf_clr together with i_wr_en while full -> o_overflow stays 1.
- Release from full: after the fill, drive i_rq2_rptr=Gray(4)=5'b00110 -> o_full=0 and o_wr_count=12 one edge later (three with the macro defined). Then 4 writes -> full again.
- Wrap: run 40 writes against a tracking reader keeping 1-3 entries outstanding -> every o_wr_ptr change flips exactly one bit, o_full never asserts, and o_wr_count matches the model.
- Async reset mid-stream: assert i_wr_rst_n low between clock edges at count=7 -> all outputs 0 immediately, without waiting for a clock edge.
